mul_unit: RTL and testbench

RV32M multiply issue/retire stage that sits directly upstream of the iterative signed multiplier core `multiply_signed`.
- Accepts MUL/MULH/MULHSU/MULHU requests from execute on a valid/ready handshake.
- Sign- or zero-extends the operands to XLEN+1 bits and launches the core with a single-cycle stb.
- On the core's ack, selects the low or high half of the product and holds it on a valid/ready response port to writeback.
- Handles flush with a drain state so the core is never restarted while still busy.

---
 rtl/mul_pkg.sv | 36 +++
 rtl/multiply_signed.sv | 75 +++++++
 rtl/mul_unit.sv | 176 +++++++++++++++++
 tb/tb_mul_unit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// mul_pkg: shared types and helpers for the RV32M multiply issue/retire stage.
//   mul_op_t    - request opcode (funct3[1:0]: MUL, MULH, MULHSU, MULHU)
//   mul_state_t - issue/retire FSM states
//   MUL_XLEN    - operand width the package helpers are built for
//   MUL_LAT     - accept-to-rsp_valid latency of an uncached operation
//   extend()    - sign/zero-extends one operand to MUL_XLEN+1 bits for the core
package mul_pkg;

  localparam int unsigned MUL_XLEN = 32;
  localparam int unsigned MUL_LAT  = MUL_XLEN + 4;

  typedef enum logic [1:0] {
    OpMul    = 2'd0,
    OpMulh   = 2'd1,
    OpMulhsu = 2'd2,
    OpMulhu  = 2'd3
  } mul_op_t;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StWait,
    StDrain,
    StDone
  } mul_state_t;

  // rs1 is signed for MULH/MULHSU, rs2 only for MULH.
  function automatic logic [MUL_XLEN:0] extend(input mul_op_t             op,
                                               input logic [MUL_XLEN-1:0] v,
                                               input logic                is_rs1);
    logic sgn;
    sgn = is_rs1 ? ((op == OpMulh) || (op == OpMulhsu)) : (op == OpMulh);
    return {sgn & v[MUL_XLEN-1], v};
  endfunction

endpackage

// File: rtl/multiply_signed.sv
// multiply_signed: iterative radix-2 two's-complement multiplier.
//   clk, rst - clock, synchronous active-high reset (aborts any operation)
//   stb      - start pulse; a/b sampled when idle
//   a, b     - signed operands (A_W, B_W bits)
//   ack      - one-cycle pulse when o holds the product
//   o        - signed product, A_W+B_W bits
// ack arrives B_W+1 cycles after the stb cycle.
module multiply_signed #(
  parameter int unsigned A_W = 33,
  parameter int unsigned B_W = 33
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stb,
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  output logic               ack,
  output logic [A_W+B_W-1:0] o
);

  localparam int unsigned P_W   = A_W + B_W;
  localparam int unsigned CNT_W = $clog2(B_W + 1);

  logic [P_W-1:0]   r_mcand;
  logic [P_W-1:0]   r_prod;
  logic [B_W-1:0]   r_mplier;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_ack;
  logic             w_last;
  logic [P_W-1:0]   w_addend;

  assign w_last = (r_cnt == CNT_W'(1));

  // The multiplier MSB carries weight -2^(B_W-1), so its partial product is subtracted.
  always_comb begin
    w_addend = '0;
    if (r_mplier[0]) begin
      w_addend = w_last ? (~r_mcand + P_W'(1)) : r_mcand;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy   <= 1'b0;
      r_ack    <= 1'b0;
      r_cnt    <= '0;
      r_prod   <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else begin
      r_ack <= 1'b0;
      if (r_busy) begin
        r_prod   <= r_prod + w_addend;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt - CNT_W'(1);
        if (w_last) begin
          r_busy <= 1'b0;
          r_ack  <= 1'b1;
        end
      end else if (stb) begin
        r_prod   <= '0;
        r_mcand  <= {{B_W{a[A_W-1]}}, a};
        r_mplier <= b;
        r_cnt    <= CNT_W'(B_W);
        r_busy   <= 1'b1;
      end
    end
  end

  assign ack = r_ack;
  assign o   = r_prod;

endmodule

// File: rtl/mul_unit.sv
// mul_unit: RV32M multiply issue/retire stage in front of multiply_signed.
//   clk, rst              - clock, synchronous active-high reset
//   req_valid/req_ready   - request handshake; req_op/req_rs1/req_rs2/req_tag payload
//   flush                 - abandon the in-flight operation
//   rsp_valid/rsp_ready   - response handshake; rsp_data/rsp_tag payload
//   busy                  - FSM not idle
// Build option MUL_FUSE_EN: caches the last completed product so a repeated
// operation retires one cycle after accept without starting the core.
module mul_unit
  import mul_pkg::*;
#(
  parameter int unsigned XLEN  = MUL_XLEN,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  mul_op_t          req_op,
  input  logic [XLEN-1:0]  req_rs1,
  input  logic [XLEN-1:0]  req_rs2,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [XLEN-1:0]  rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
);

  localparam int unsigned EXT_W = XLEN + 1;
  localparam int unsigned P_W   = 2 * EXT_W;

  mul_state_t       r_state;
  mul_op_t          r_op;
  logic [EXT_W-1:0] r_a;
  logic [EXT_W-1:0] r_b;
  logic [TAG_W-1:0] r_tag;
  logic [XLEN-1:0]  r_rsp_data;
  logic             r_rsp_valid;

  logic [EXT_W-1:0] w_ext_a;
  logic [EXT_W-1:0] w_ext_b;
  logic             w_stb;
  logic             w_ack;
  logic [P_W-1:0]   w_prod;
  logic             w_hit;
  logic [XLEN-1:0]  w_hit_data;
  logic             w_unused_prod_hi;

  function automatic logic [XLEN-1:0] sel_half(input mul_op_t op, input logic [2*XLEN-1:0] p);
    return (op == OpMul) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  assign w_ext_a = extend(req_op, req_rs1, 1'b1);
  assign w_ext_b = extend(req_op, req_rs2, 1'b0);
  assign w_stb   = (r_state == StStart);

  // Bits above 2*XLEN only hold sign extension of the selected halves.
  assign w_unused_prod_hi = ^w_prod[P_W-1:2*XLEN];

  multiply_signed #(
    .A_W (EXT_W),
    .B_W (EXT_W)
  ) u_core (
    .clk (clk),
    .rst (rst),
    .stb (w_stb),
    .a   (r_a),
    .b   (r_b),
    .ack (w_ack),
    .o   (w_prod)
  );

`ifdef MUL_FUSE_EN
  logic              r_c_valid;
  logic [EXT_W-1:0]  r_c_a;
  logic [EXT_W-1:0]  r_c_b;
  logic [XLEN-1:0]   r_c_rs1;
  logic [XLEN-1:0]   r_c_rs2;
  logic [2*XLEN-1:0] r_c_prod;
  logic [XLEN-1:0]   r_rs1;
  logic [XLEN-1:0]   r_rs2;

  // MUL's low half does not depend on extension, so raw operands suffice for it.
  assign w_hit = r_c_valid &&
                 (((w_ext_a == r_c_a) && (w_ext_b == r_c_b)) ||
                  ((req_op == OpMul) && (req_rs1 == r_c_rs1) && (req_rs2 == r_c_rs2)));
  assign w_hit_data = sel_half(req_op, r_c_prod);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_c_valid <= 1'b0;
    end else begin
      if ((r_state == StIdle) && req_valid) begin
        r_rs1 <= req_rs1;
        r_rs2 <= req_rs2;
      end
      // Product is exact even if the response is flushed this cycle.
      if ((r_state == StWait) && w_ack) begin
        r_c_valid <= 1'b1;
        r_c_a     <= r_a;
        r_c_b     <= r_b;
        r_c_rs1   <= r_rs1;
        r_c_rs2   <= r_rs2;
        r_c_prod  <= w_prod[2*XLEN-1:0];
      end
    end
  end
`else
  assign w_hit      = 1'b0;
  assign w_hit_data = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_op        <= OpMul;
      r_a         <= '0;
      r_b         <= '0;
      r_tag       <= '0;
      r_rsp_data  <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (req_valid) begin
            r_op  <= req_op;
            r_a   <= w_ext_a;
            r_b   <= w_ext_b;
            r_tag <= req_tag;
            if (w_hit) begin
              r_rsp_data  <= w_hit_data;
              r_rsp_valid <= 1'b1;
              r_state     <= StDone;
            end else begin
              r_state <= StStart;
            end
          end
        end
        // stb is still issued on flush so the drain can count on an ack.
        StStart: r_state <= flush ? StDrain : StWait;
        StWait: begin
          if (w_ack) begin
            if (flush) begin
              r_state <= StIdle;
            end else begin
              r_rsp_data  <= sel_half(r_op, w_prod[2*XLEN-1:0]);
              r_rsp_valid <= 1'b1;
              r_state     <= StDone;
            end
          end else if (flush) begin
            r_state <= StDrain;
          end
        end
        StDrain: begin
          if (w_ack) r_state <= StIdle;
        end
        StDone: begin
          if (flush || rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign req_ready = (r_state == StIdle);
  assign busy      = (r_state != StIdle);
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_tag   = r_tag;

endmodule

// File: tb/tb_mul_unit.sv
// tb_mul_unit: directed scoreboard bench for mul_unit.
module tb_mul_unit;
  import mul_pkg::*;

  localparam int LAT = 36;
`ifdef MUL_FUSE_EN
  localparam int FUSE_LAT = 1;
`else
  localparam int FUSE_LAT = 36;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  mul_op_t     req_op = OpMul;
  logic [31:0] req_rs1 = '0;
  logic [31:0] req_rs2 = '0;
  logic [4:0]  req_tag = '0;
  logic        flush = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_tag;
  logic        busy;

  mul_unit #(
    .XLEN  (32),
    .TAG_W (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_rs1   (req_rs1),
    .req_rs2   (req_rs2),
    .req_tag   (req_tag),
    .flush     (flush),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_tag   (rsp_tag),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic [4:0]  tag;
    int          lat;
    int          t_acc;
  } exp_t;

  exp_t sb[$];
  logic prev_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: compares every response cycle against the scoreboard head.
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL unexpected_rsp: got data %h tag %h want no response", rsp_data, rsp_tag);
      end else begin
        if (!prev_valid)
          chk({sb[0].name, " latency"}, 32'(cyc - sb[0].t_acc), 32'(sb[0].lat));
        chk({sb[0].name, " data"}, rsp_data, sb[0].data);
        chk({sb[0].name, " tag"}, {27'b0, rsp_tag}, {27'b0, sb[0].tag});
        chk({sb[0].name, " req_ready"}, {31'b0, req_ready}, 32'd0);
        if (rsp_ready) void'(sb.pop_front());
      end
    end
    prev_valid = rsp_valid;
  end

  task automatic issue(input string name, input mul_op_t op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag, input logic [31:0] d,
                       input int lat, input bit push, output int t_acc);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_op    = op;
    req_rs1   = a;
    req_rs2   = b;
    req_tag   = tag;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    t_acc = cyc;
    if (!req_ready) begin
      n_total++;
      n_bad++;
      $display("FAIL %s accept: got req_ready 0 want 1 within 100 cycles", name);
    end else if (push) begin
      sb.push_back('{name, d, tag, lat, cyc});
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_total++;
      n_bad++;
      $display("FAIL %s rsp_timeout: got %0d pending want 0", name, sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    int h;
    int n;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("reset rsp_data", rsp_data, 32'd0);
    chk("reset rsp_tag", {27'b0, rsp_tag}, 32'd0);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset req_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1;

    issue("mul_7_m3", OpMul, 32'd7, 32'hFFFF_FFFD, 5'd9, 32'hFFFF_FFEB, LAT, 1'b1, t);
    wait_done("mul_7_m3");
    issue("mulh_min", OpMulh, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, LAT, 1'b1, t);
    wait_done("mulh_min");
    issue("mulhu_min", OpMulhu, 32'h8000_0000, 32'h8000_0000, 5'd2, 32'h4000_0000, LAT, 1'b1, t);
    wait_done("mulhu_min");
    issue("mulhsu_ones", OpMulhsu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, LAT,
          1'b1, t);
    wait_done("mulhsu_ones");
    issue("mulhu_ones", OpMulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFE, LAT,
          1'b1, t);
    wait_done("mulhu_ones");

    // Backpressure: hold the response, then accept on the cycle after the handshake.
    rsp_ready = 1'b0;
    issue("bp_mul", OpMul, 32'h0001_2345, 32'h0000_0100, 5'd21, 32'h0123_4500, LAT, 1'b1, t);
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    h = cyc;
    issue("bp_next", OpMul, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd22, 32'h0000_0001, LAT, 1'b1, t);
    chk("bp accept cycle", 32'(t), 32'(h + 1));
    wait_done("bp_next");

    // Flush five cycles after accept: no response, ready back only after the drained ack.
    issue("flush_mul", OpMul, 32'd5, 32'd5, 5'd7, 32'd25, LAT, 1'b0, t);
    for (int i = 0; i < 36; i++) begin
      flush = (cyc == t + 5);
      @(negedge clk);
      chk("flush req_ready", {31'b0, req_ready}, (cyc - t >= 36) ? 32'd1 : 32'd0);
      @(posedge clk);
      #1;
    end
    flush = 1'b0;
    issue("mul_2_3", OpMul, 32'd2, 32'd3, 5'd8, 32'd6, LAT, 1'b1, t);
    wait_done("mul_2_3");

    // Reset in the middle of WAIT.
    issue("rst_victim", OpMulhu, 32'h0000_1234, 32'h0000_0010, 5'd30, 32'd0, LAT, 1'b0, t);
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("midrst rsp_data", rsp_data, 32'd0);
    chk("midrst rsp_tag", {27'b0, rsp_tag}, 32'd0);
    chk("midrst busy", {31'b0, busy}, 32'd0);
    chk("midrst req_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    issue("mulhu_post_rst", OpMulhu, 32'hFFFF_FFFF, 32'd2, 5'd11, 32'd1, LAT, 1'b1, t);
    wait_done("mulhu_post_rst");

    // Repeated operands: fused build retires the MUL from the cache.
    issue("fuse_mulh", OpMulh, 32'h1234_5678, 32'h9ABC_DEF0, 5'd12, 32'hF8CC_93D6, LAT, 1'b1, t);
    wait_done("fuse_mulh");
    issue("fuse_mul", OpMul, 32'h1234_5678, 32'h9ABC_DEF0, 5'd13, 32'h242D_2080, FUSE_LAT,
          1'b1, t);
    wait_done("fuse_mul");

    repeat (3) @(negedge clk);
    chk("final idle", {31'b0, busy}, 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
